// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the byte-stream program loader.
//   state_t      : loader FSM states
//   HDR_*        : frame header codes selecting the target memory
//   WSEL_*       : encodings for the downstream memory write_select input
package mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        COUNT,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] HDR_INST = 8'h00;
    localparam logic [7:0] HDR_DATA = 8'h01;

    localparam logic [1:0] WSEL_INST = 2'd0;
    localparam logic [1:0] WSEL_DATA = 2'd1;
    localparam logic [1:0] WSEL_NONE = 2'd2;

endpackage

// File: rtl/mem_loader_byte_shift32.sv
// byte_shift32: little-endian byte assembler shared by the address, count and
// payload fields of a frame.
//   clk, rst  : clock, synchronous active-high reset (discards a partial field)
//   i_shift   : accept i_byte this cycle
//   i_byte    : incoming byte, placed at the lane selected by the byte counter
//   i_nbytes  : field length in bytes (2 or 4)
//   o_word    : assembled field including the byte being accepted now
//   o_full    : the byte accepted now completes the field
module byte_shift32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    input  logic [2:0]  i_nbytes,
    output logic [31:0] o_word,
    output logic        o_full
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    // The combined view lets the caller consume a complete field on the same
    // edge that its final byte arrives.
    always_comb begin
        o_word = r_word;
        o_word[{r_cnt, 3'b000} +: 8] = i_byte;
        o_full = i_shift && ({1'b0, r_cnt} == (i_nbytes - 3'd1));
    end

    // Clearing on completion keeps the upper bytes zero for short fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            if (o_full) begin
                r_word <= '0;
                r_cnt  <= '0;
            end else begin
                r_word <= o_word;
                r_cnt  <= r_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: parses framed byte stream (header, 32-bit start address, 16-bit
// word count, payload) and writes little-endian 32-bit words into instruction
// or data memory at consecutive word addresses, after range checking the frame.
//   clk, rst            : clock, synchronous active-high reset
//   in_data, in_valid   : stream byte and its qualifier
//   in_ready            : byte accepted on edges where in_valid & in_ready
//   mem_addr, mem_wdata : word address and data to the memory
//   mem_wsel            : 0 = instruction, 1 = data, 2 = no write
//   busy                : frame in progress
//   done, err           : one-cycle pulses for completed / rejected frame
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int INST_SIZE = 4096,
    parameter int DATA_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_wsel,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    state_t      w_next;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_wsel;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_target;      // 1 = data memory
    logic [31:0] r_addr;        // address of the next word to write
    logic [15:0] r_remain;      // words still to write

    logic        w_accept;
    logic        w_shift;
    logic [2:0]  w_nbytes;
    logic [31:0] w_asm;
    logic        w_full;
    logic [15:0] w_count;
    logic [32:0] w_end;
    logic [32:0] w_limit;
    logic        w_range_ok;

    assign w_accept = in_valid & r_in_ready;
    assign w_count  = w_asm[15:0];

    // 33-bit sum so a start address near 2^32 cannot wrap past the check.
    assign w_end      = {1'b0, r_addr} + {17'd0, w_count};
    assign w_limit    = r_target ? 33'(DATA_SIZE) : 33'(INST_SIZE);
    assign w_range_ok = (w_end <= w_limit);

    byte_shift32 u_shift (
        .clk      (clk),
        .rst      (rst),
        .i_shift  (w_shift),
        .i_byte   (in_data),
        .i_nbytes (w_nbytes),
        .o_word   (w_asm),
        .o_full   (w_full)
    );

    always_comb begin
        w_next   = r_state;
        w_shift  = 1'b0;
        w_nbytes = 3'd4;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_data == HDR_INST || in_data == HDR_DATA) w_next = ADDR;
                    else                                            w_next = ERR;
                end
            end
            ADDR: begin
                w_shift = w_accept;
                if (w_full) w_next = COUNT;
            end
            COUNT: begin
                w_shift  = w_accept;
                w_nbytes = 3'd2;
                if (w_full) begin
                    if (!w_range_ok)          w_next = ERR;
                    else if (w_count == '0)   w_next = DONE;
                    else                      w_next = DATA;
                end
            end
            DATA: begin
                w_shift = w_accept;
                if (w_full) w_next = WRITE;
            end
            WRITE:   w_next = (r_remain == 16'd1) ? DONE : DATA;
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wsel      <= WSEL_NONE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_target    <= 1'b0;
            r_addr      <= '0;
            r_remain    <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == IDLE) || (w_next == ADDR) ||
                          (w_next == COUNT) || (w_next == DATA);
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == DONE);
            r_err      <= (w_next == ERR);
            r_wsel     <= (w_next == WRITE) ? (r_target ? WSEL_DATA : WSEL_INST)
                                            : WSEL_NONE;
            if (r_state == IDLE && w_accept) r_target <= (in_data == HDR_DATA);
            if (r_state == ADDR && w_full)   r_addr   <= w_asm;
            if (r_state == COUNT && w_full)  r_remain <= w_count;
            if (w_next == WRITE) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_asm;
            end
            if (r_state == WRITE) begin
                r_addr   <= r_addr + 32'd1;
                r_remain <= r_remain - 16'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_wsel  = r_wsel;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int ISZ = 4096;
    localparam int DSZ = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_wsel;
    logic        busy;
    logic        done;
    logic        err;

    mem_loader #(.INST_SIZE(ISZ), .DATA_SIZE(DSZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wsel  (mem_wsel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observed memory writes and pulses, sampled mid-cycle.
    typedef struct packed {
        logic [1:0]  wsel;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t got_q[$];
    int  done_cnt  = 0;
    int  err_cnt   = 0;
    int  ready_bad = 0;

    always @(negedge clk) begin
        wr_t w;
        if (mem_wsel !== WSEL_NONE) begin
            w.wsel = mem_wsel;
            w.addr = mem_addr;
            w.data = mem_wdata;
            got_q.push_back(w);
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1)  err_cnt++;
        if (in_ready === 1'b1 && (mem_wsel !== WSEL_NONE || done === 1'b1 || err === 1'b1))
            ready_bad++;
    end

    // Reference: a frame is rejected for a bad header or when its writes
    // would run past the end of the target memory.
    function automatic bit model_reject(input logic [7:0] hdr, input logic [31:0] addr, input int n);
        longint a;
        longint lim;
        if (hdr != 8'h00 && hdr != 8'h01) return 1'b1;
        a   = longint'({32'd0, addr});
        lim = (hdr == 8'h01) ? longint'(DSZ) : longint'(ISZ);
        return (a + longint'(n)) > lim;
    endfunction

    // Offer one byte, optionally after random idle cycles; returns just after
    // the edge on which it was transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            errors++;
            checks++;
            $display("FAIL byte_timeout: in_ready stayed 0 for byte 0x%0h", b);
        end
        @(posedge clk);
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] addr;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          gaps;
        bit          exp_err;
    } frame_t;

    task automatic run_frame(input frame_t f, input bit exp_err, input string nm);
        logic [31:0] words[$];
        wr_t         exp_q[$];
        wr_t         e;
        logic [1:0]  tsel;
        logic [15:0] nn;
        logic [31:0] wd;
        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        nn   = f.n[15:0];
        tsel = (f.hdr == 8'h01) ? WSEL_DATA : WSEL_INST;
        for (int i = 0; i < f.n; i++)
            words.push_back(i == 0 ? f.w0 : (i == 1 ? f.w1 : $urandom()));
        if (!model_reject(f.hdr, f.addr, f.n)) begin
            for (int i = 0; i < f.n; i++) begin
                e.wsel = tsel;
                e.addr = f.addr + 32'(i);
                e.data = words[i];
                exp_q.push_back(e);
            end
        end

        send_byte(f.hdr, f.gaps);
        if (f.hdr == 8'h00 || f.hdr == 8'h01) begin
            for (int i = 0; i < 4; i++) send_byte(f.addr[8*i +: 8], f.gaps);
            for (int i = 0; i < 2; i++) send_byte(nn[8*i +: 8], f.gaps);
            if (!exp_err) begin
                for (int w = 0; w < f.n; w++) begin
                    wd = words[w];
                    for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8], f.gaps);
                    #1;
                    chk({nm, "_wsel_lat"}, 32'(mem_wsel), 32'(tsel));
                    chk({nm, "_addr_lat"}, mem_addr, f.addr + 32'(w));
                    chk({nm, "_ready_wr"}, 32'(in_ready), 32'd0);
                end
            end
        end
        if (exp_err) begin
            #1 chk({nm, "_err_next"}, 32'(err), 32'd1);
        end else if (f.n == 0) begin
            #1 chk({nm, "_done_next"}, 32'(done), 32'd1);
            chk({nm, "_wsel_none"}, 32'(mem_wsel), 32'(WSEL_NONE));
        end else begin
            @(posedge clk);
            #1 chk({nm, "_done_after_wr"}, 32'(done), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        chk({nm, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({nm, "_wr_sel"},  32'(got_q[i].wsel), 32'(exp_q[i].wsel));
            chk({nm, "_wr_addr"}, got_q[i].addr, exp_q[i].addr);
            chk({nm, "_wr_data"}, got_q[i].data, exp_q[i].data);
        end
        chk({nm, "_done_cnt"}, 32'(done_cnt), exp_err ? 32'd0 : 32'd1);
        chk({nm, "_err_cnt"},  32'(err_cnt),  exp_err ? 32'd1 : 32'd0);
        chk({nm, "_idle"},     32'(busy),     32'd0);
    endtask

    frame_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t rf;
        bit     rej;

        tbl[0] = '{8'h00, 32'h0000_0010, 2, 32'hDEADBEEF, 32'h01020304, 1'b0, 1'b0};
        tbl[1] = '{8'h01, 32'h0000_0000, 0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[2] = '{8'h07, 32'h0000_0000, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[3] = '{8'h01, 32'h0000_0FFF, 2, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[4] = '{8'h01, 32'h0000_0FFF, 1, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 32'h0000_0FFE, 2, 32'h11223344, 32'h55667788, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 32'h0000_1000, 0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[7] = '{8'h01, 32'hFFFF_FFFF, 1, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[8] = '{8'h00, 32'h0000_0020, 5, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b1, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wsel",  32'(mem_wsel), 32'(WSEL_NONE));
        chk("rst_addr",  mem_addr,      32'd0);
        chk("rst_wdata", mem_wdata,     32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_err",   32'(err),      32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_rst", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i], tbl[i].exp_err, $sformatf("tbl%0d", i));
        end

        // Same content as the first frame, with in_valid gaps inside words.
        rf = tbl[0];
        rf.gaps = 1'b1;
        run_frame(rf, 1'b0, "gapped");

        // Reset after two payload bytes abandons the frame silently.
        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy),     32'd0);
        chk("abort_wsel", 32'(mem_wsel), 32'(WSEL_NONE));
        chk("abort_done", 32'(done),     32'd0);
        chk("abort_err",  32'(err),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_nwrites", 32'(got_q.size()), 32'd0);
        chk("abort_pulses",  32'(done_cnt + err_cnt), 32'd0);
        run_frame(tbl[0], 1'b0, "after_abort");

        // Randomised frames judged by the reference model.
        for (int k = 0; k < 8; k++) begin
            rf.hdr     = ($urandom_range(0, 7) == 0) ? 8'h05 : 8'($urandom_range(0, 1));
            rf.addr    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(4088, 4100))
                                                     : 32'($urandom_range(0, 200));
            rf.n       = $urandom_range(0, 6);
            rf.w0      = $urandom();
            rf.w1      = $urandom();
            rf.gaps    = 1'b1;
            rej        = model_reject(rf.hdr, rf.addr, rf.n);
            rf.exp_err = rej;
            run_frame(rf, rej, $sformatf("rand%0d", k));
        end

        chk("ready_low_when_busy_out", 32'(ready_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
